vec_operand_mem: RTL and testbench
==================================

Name: vec_operand_mem

Overview:
- Parametrised operand staging memory for the s_tile vector FU.
- Generalises the fixed two-vector/one-config store:
  - num_ports independent vector write channels, each backed by a depth-entry FIFO.
  - A handshaked config register.
  - A valid/ready read side that issues one full operand bundle (one vector per port) per transaction to the adder array.
- Sits between the tile's routing inputs and the vector FU.

Parameters:
- width, 16, bits per lane.
- num_inputs, 4, lanes per vector.
- num_ports, 2, vector write channels; legal range 1..8.
- depth, 2, vectors buffered per port; power of 2, at least 2.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous reset, active-high.
- on_off  in  1  tile enable for the read side.
- write_en  in  num_ports  per-port write request.
- write_rdy  out  num_ports  per-port FIFO not full.
- write_ack  out  num_ports  per-port one-cycle accept acknowledge.
- w_data_in  in  num_ports*num_inputs*width  port p lane i at [(p*num_inputs+i)*width +: width].
- cfg_write_en  in  1  config write request.
- cfg_write_rdy  out  1  config writable.
- cfg_write_ack  out  1  one-cycle config acknowledge.
- cfg_data_in  in  width  config word.
- config_in  out  width  current config register.
- adder_inputs  out  num_ports*num_inputs*width  issued bundle; same packing as w_data_in.
- r_data_vld  out  1  bundle valid.
- r_data_rdy  in  1  consumer accepts bundle.
- on_off_vector_fu  out  1  FU enable.

Behaviour:
- Reset values:
  - write_rdy all 1.
  - write_ack, cfg_write_ack, r_data_vld, on_off_vector_fu all 0.
  - config_in 0; cfg_valid flag 0.
  - adder_inputs 0.
  - All FIFO counts and pointers 0; FSM in IDLE.
- Vector write, per port p:
  - Accept at a clk edge when write_en[p] && write_rdy[p] && !write_ack[p].
  - On accept, the vector is stored at the tail and write_ack[p]=1 for exactly the next cycle.
  - Because of the !write_ack term, a producer holding en through the ack cycle writes only once.
  - write_rdy[p] = (count_p < depth), derived from registered count.
  - A full FIFO never accepts; a pop in the same cycle does not make it accept that cycle.
  - Simultaneous push and pop on a non-full, non-empty FIFO leaves count unchanged.
  - Pointers wrap modulo depth.
- Config write:
  - cfg_write_rdy = !on_off || state==IDLE.
  - Accept when cfg_write_en && cfg_write_rdy && !cfg_write_ack.
  - On accept: config_in <= cfg_data_in, cfg_valid <= 1, cfg_write_ack pulses one cycle.
- on_off_vector_fu = registered (on_off && cfg_valid && config_in[0]).
- Read FSM:
  - IDLE -> LOAD when on_off && cfg_valid && every port count > 0.
  - LOAD (one cycle): copy each port's head vector into adder_inputs; go to VALID.
  - VALID:
    - r_data_vld=1; adder_inputs held stable.
    - On r_data_vld && r_data_rdy: pop the head of every port in that same edge, drop vld, return to IDLE.
    - If on_off is low in VALID: abort to IDLE, vld 0 next cycle, no pop, data stays buffered.
- Latency:
  - r_data_vld rises 2 cycles after the IDLE->LOAD condition is first true.
  - Minimum 3 cycles per bundle (IDLE, LOAD, VALID).
- Reset asserted mid-operation: all state cleared immediately; buffered data discarded.

Test Plan:
- Reset, then write cfg 0x0001 -> cfg_write_ack for exactly 1 cycle; config_in=0x0001; on_off_vector_fu=0 until on_off=1, then 1 next cycle.
- Ports 0/1 write {1,2,3,4} and {10,20,30,40} in parallel with en held through ack; on_off=1; r_data_rdy=1:
  - Each write_ack pulses once; count per port = 1.
  - r_data_vld rises 2 cycles after the condition.
  - adder_inputs lanes 0..7 = 1,2,3,4,0x0A,0x14,0x1E,0x28.
  - FIFOs empty after the handshake.
- Fill port 0 with 2 vectors (depth=2) -> write_rdy[0]=0; a third en is ignored (no ack) until a pop; after the pop, the third vector is accepted.
- on_off=1, r_data_rdy=0 for 5 cycles -> vld and adder_inputs stable; on_off dropped -> vld 0 next cycle, counts unchanged; on_off=1 again -> same bundle re-issued.
- Port 1 empty while port 0 holds data -> no LOAD; writing port 1 -> bundle issued.
- Assert reset in VALID -> outputs at reset values the same cycle; all write_rdy=1.

Source files
------------

// File: rtl/vec_operand_mem.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : vec_operand_mem
// Purpose  : Per-port vector FIFOs, handshaked config register and a
//            valid/ready bundle issue path feeding the s_tile vector FU.
// Revision : 1.0 - initial release
// ============================================================================
module vec_operand_mem #(
  parameter int WIDTH      = 16,
  parameter int NUM_INPUTS = 4,
  parameter int NUM_PORTS  = 2,
  parameter int DEPTH      = 2
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                on_off,
  input  logic [NUM_PORTS-1:0]                write_en,
  output logic [NUM_PORTS-1:0]                write_rdy,
  output logic [NUM_PORTS-1:0]                write_ack,
  input  logic [NUM_PORTS*NUM_INPUTS*WIDTH-1:0] w_data_in,
  input  logic                                cfg_write_en,
  output logic                                cfg_write_rdy,
  output logic                                cfg_write_ack,
  input  logic [WIDTH-1:0]                    cfg_data_in,
  output logic [WIDTH-1:0]                    config_in,
  output logic [NUM_PORTS*NUM_INPUTS*WIDTH-1:0] adder_inputs,
  output logic                                r_data_vld,
  input  logic                                r_data_rdy,
  output logic                                on_off_vector_fu
);

  localparam int c_vec_w = NUM_INPUTS * WIDTH;
  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_cnt_w = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    VALID = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [NUM_PORTS-1:0]              w_nonempty;
  logic [NUM_PORTS-1:0][c_vec_w-1:0] w_head;
  logic                              w_all_ready;
  logic                              w_pop;
  logic                              w_cfg_accept;
  logic                              r_cfg_valid;

  assign w_all_ready   = &w_nonempty;
  // A handshake pops every port together, so heads stay aligned across ports.
  assign w_pop         = (r_state == VALID) && r_data_rdy;
  assign r_data_vld    = (r_state == VALID);
  assign cfg_write_rdy = !on_off || (r_state == IDLE);
  assign w_cfg_accept  = cfg_write_en && cfg_write_rdy && !cfg_write_ack;

  genvar p;
  generate
    for (p = 0; p < NUM_PORTS; p++) begin : g_port
      logic [c_vec_w-1:0] r_mem [DEPTH];
      logic [c_ptr_w-1:0] r_wr_ptr;
      logic [c_ptr_w-1:0] r_rd_ptr;
      logic [c_cnt_w-1:0] r_count;
      logic               r_ack;
      logic               w_push;

      assign write_rdy[p]  = (r_count < c_cnt_w'(DEPTH));
      // Blocking on the pending ack stops a producer holding en from double-writing.
      assign w_push        = write_en[p] && write_rdy[p] && !r_ack;
      assign write_ack[p]  = r_ack;
      assign w_nonempty[p] = (r_count != '0);
      assign w_head[p]     = r_mem[r_rd_ptr];

      always_ff @(posedge clk) begin
        if (w_push) begin
          r_mem[r_wr_ptr] <= w_data_in[p*c_vec_w +: c_vec_w];
        end
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_wr_ptr <= '0;
          r_rd_ptr <= '0;
          r_count  <= '0;
          r_ack    <= 1'b0;
        end else begin
          r_ack <= w_push;
          if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
          if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
          if (w_push && !w_pop) begin
            r_count <= r_count + c_cnt_w'(1);
          end else if (!w_push && w_pop) begin
            r_count <= r_count - c_cnt_w'(1);
          end
        end
      end
    end
  endgenerate

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (on_off && r_cfg_valid && w_all_ready) w_state_nxt = LOAD;
      LOAD:    w_state_nxt = VALID;
      VALID:   if (r_data_rdy || !on_off) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      adder_inputs <= '0;
    end else if (r_state == LOAD) begin
      adder_inputs <= w_head;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      config_in        <= '0;
      r_cfg_valid      <= 1'b0;
      cfg_write_ack    <= 1'b0;
      on_off_vector_fu <= 1'b0;
    end else begin
      cfg_write_ack    <= w_cfg_accept;
      on_off_vector_fu <= on_off && r_cfg_valid && config_in[0];
      if (w_cfg_accept) begin
        config_in   <= cfg_data_in;
        r_cfg_valid <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vec_operand_mem.sv
`timescale 1ns/1ps
`default_nettype none
// Scoreboard bench for vec_operand_mem: per-port reference queues plus
// directed scenarios and a randomized phase.
module tb_vec_operand_mem;

  localparam int W     = 16;
  localparam int NI    = 4;
  localparam int NP    = 2;
  localparam int DEPTH = 2;
  localparam int VW    = NI * W;
  localparam int BW    = NP * VW;

  typedef logic [VW-1:0] vec_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          on_off = 1'b0;
  logic [NP-1:0] write_en = '0;
  logic [NP-1:0] write_rdy;
  logic [NP-1:0] write_ack;
  logic [BW-1:0] w_data_in = '0;
  logic          cfg_write_en = 1'b0;
  logic          cfg_write_rdy;
  logic          cfg_write_ack;
  logic [W-1:0]  cfg_data_in = '0;
  logic [W-1:0]  config_in;
  logic [BW-1:0] adder_inputs;
  logic          r_data_vld;
  logic          r_data_rdy = 1'b0;
  logic          on_off_vector_fu;

  int n_cmp = 0;
  int n_err = 0;

  vec_operand_mem #(
    .WIDTH(W), .NUM_INPUTS(NI), .NUM_PORTS(NP), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .on_off(on_off),
    .write_en(write_en), .write_rdy(write_rdy), .write_ack(write_ack),
    .w_data_in(w_data_in),
    .cfg_write_en(cfg_write_en), .cfg_write_rdy(cfg_write_rdy),
    .cfg_write_ack(cfg_write_ack), .cfg_data_in(cfg_data_in),
    .config_in(config_in), .adder_inputs(adder_inputs),
    .r_data_vld(r_data_vld), .r_data_rdy(r_data_rdy),
    .on_off_vector_fu(on_off_vector_fu)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t vec4(input int a, input int b, input int c, input int d);
    return {W'(d), W'(c), W'(b), W'(a)};
  endfunction

  // Reference model: one queue of accepted vectors per port.
  vec_t          m_q [NP][$];
  logic [NP-1:0] m_ack = '0;
  logic [NP-1:0] m_acc;
  logic          m_cfg_ack = 1'b0;
  logic          m_cfg_valid = 1'b0;
  logic          m_fu = 1'b0;
  logic [W-1:0]  m_cfg = '0;
  bit            pend_pop = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int p = 0; p < NP; p++) m_q[p].delete();
      m_ack = '0; m_cfg_ack = 1'b0; m_cfg_valid = 1'b0; m_fu = 1'b0;
      m_cfg = '0; pend_pop = 1'b0;
    end else begin
      for (int p = 0; p < NP; p++)
        m_acc[p] = write_en[p] && (m_q[p].size() < DEPTH) && !m_ack[p];
      if (pend_pop)
        for (int p = 0; p < NP; p++)
          if (m_q[p].size() > 0) void'(m_q[p].pop_front());
      pend_pop = 1'b0;
      for (int p = 0; p < NP; p++)
        if (m_acc[p]) m_q[p].push_back(w_data_in[p*VW +: VW]);
      m_ack = m_acc;
      m_fu  = on_off && m_cfg_valid && m_cfg[0];
      if (cfg_write_en && !on_off && !m_cfg_ack) begin
        m_cfg = cfg_data_in; m_cfg_valid = 1'b1; m_cfg_ack = 1'b1;
      end else begin
        m_cfg_ack = 1'b0;
      end
    end
  end

  logic [BW-1:0] mon_exp;
  bit            mon_ne;

  always @(negedge clk) begin
    for (int p = 0; p < NP; p++) begin
      chk("write_ack", write_ack[p], m_ack[p]);
      chk("write_rdy", write_rdy[p], m_q[p].size() < DEPTH);
    end
    chk("cfg_write_ack", cfg_write_ack, m_cfg_ack);
    chk("config_in", config_in, m_cfg);
    chk("on_off_vector_fu", on_off_vector_fu, m_fu);
    if (!on_off) chk("cfg_write_rdy", cfg_write_rdy, 1'b1);
    if (r_data_vld) begin
      mon_ne = 1'b1;
      for (int p = 0; p < NP; p++) if (m_q[p].size() == 0) mon_ne = 1'b0;
      chk("vld_with_data", mon_ne, 1'b1);
      if (r_data_rdy && mon_ne) begin
        for (int p = 0; p < NP; p++) mon_exp[p*VW +: VW] = m_q[p][0];
        chk("bundle", adder_inputs, mon_exp);
        pend_pop = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_vld();
    int k = 0;
    while (!r_data_vld && k < 20) begin
      tick();
      k++;
    end
    chk("vld_timeout", r_data_vld, 1'b1);
  endtask

  task automatic cfg_write(input logic [W-1:0] d);
    on_off = 1'b0; r_data_rdy = 1'b0;
    cfg_data_in = d; cfg_write_en = 1'b1;
    tick(); chk("cfg_ack_pulse", cfg_write_ack, 1'b1);
    tick(); chk("cfg_ack_once", cfg_write_ack, 1'b0);
    cfg_write_en = 1'b0;
    chk("cfg_value", config_in, d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  logic [BW-1:0] cap;
  vec_t va, vb, vc, vd;
  bit   ne;

  initial begin
    #1 reset = 1'b1;
    tick(); tick();
    chk("rst_write_rdy", write_rdy, 2'b11);
    chk("rst_write_ack", write_ack, 2'b00);
    chk("rst_cfg_ack", cfg_write_ack, 1'b0);
    chk("rst_vld", r_data_vld, 1'b0);
    chk("rst_fu", on_off_vector_fu, 1'b0);
    chk("rst_config", config_in, 16'h0);
    chk("rst_adder", adder_inputs, '0);
    reset = 1'b0;
    tick();

    // Config write and FU enable
    cfg_write(16'h0001);
    chk("fu_before_on", on_off_vector_fu, 1'b0);
    on_off = 1'b1;
    tick();
    chk("fu_after_on", on_off_vector_fu, 1'b1);

    // Parallel writes, en held through the ack cycle
    r_data_rdy = 1'b1;
    w_data_in  = {vec4(10, 20, 30, 40), vec4(1, 2, 3, 4)};
    write_en   = 2'b11;
    tick(); chk("ack_both", write_ack, 2'b11);
    tick(); chk("ack_once", write_ack, 2'b00); chk("vld_in_load", r_data_vld, 1'b0);
    write_en = 2'b00;
    tick(); chk("vld_latency", r_data_vld, 1'b1);
    chk("bundle_first", adder_inputs, {vec4(10, 20, 30, 40), vec4(1, 2, 3, 4)});
    tick(); chk("vld_drop", r_data_vld, 1'b0);
    repeat (4) begin tick(); chk("no_reissue", r_data_vld, 1'b0); end

    // Fill port 0, port 1 empty
    va = vec4(5, 6, 7, 8); vb = vec4(9, 11, 12, 13);
    vc = vec4(14, 15, 16, 17); vd = vec4(100, 200, 300, 400);
    w_data_in[0 +: VW] = va; write_en = 2'b01; tick(); write_en = 2'b00; tick();
    w_data_in[0 +: VW] = vb; write_en = 2'b01; tick(); write_en = 2'b00; tick();
    chk("full_rdy", write_rdy[0], 1'b0);
    w_data_in[0 +: VW] = vc; write_en = 2'b01;
    repeat (3) begin
      tick(); chk("full_no_ack", write_ack[0], 1'b0); chk("no_load", r_data_vld, 1'b0);
    end
    w_data_in[VW +: VW] = vd; write_en = 2'b11;
    tick(); chk("ack_port1", write_ack, 2'b10);
    write_en = 2'b01;
    tick(); chk("p1_load", r_data_vld, 1'b0);
    tick(); chk("p1_vld", r_data_vld, 1'b1); chk("bundle_ad", adder_inputs, {vd, va});
    tick(); chk("pop_vld_drop", r_data_vld, 1'b0);
    chk("pop_no_accept", write_ack[0], 1'b0); chk("rdy_after_pop", write_rdy[0], 1'b1);
    tick(); chk("accept_after_pop", write_ack[0], 1'b1);
    write_en = 2'b00;
    repeat (2) begin
      w_data_in[VW +: VW] = {$urandom, $urandom};
      write_en = 2'b10; tick(); write_en = 2'b00;
      repeat (6) tick();
    end

    // Stall, abort and re-issue
    r_data_rdy = 1'b0;
    w_data_in = {$urandom, $urandom, $urandom, $urandom};
    write_en = 2'b11; tick(); write_en = 2'b00;
    wait_vld();
    cap = adder_inputs;
    repeat (5) begin
      tick(); chk("stall_vld", r_data_vld, 1'b1); chk("stall_data", adder_inputs, cap);
    end
    on_off = 1'b0;
    tick(); chk("abort_vld", r_data_vld, 1'b0); chk("abort_rdy", write_rdy, 2'b11);
    tick(); chk("abort_idle", r_data_vld, 1'b0);
    on_off = 1'b1;
    wait_vld(); chk("reissue_data", adder_inputs, cap);
    r_data_rdy = 1'b1;
    tick(); chk("reissue_pop", r_data_vld, 1'b0);
    r_data_rdy = 1'b0;

    // Reset while VALID with both FIFOs full
    w_data_in = {$urandom, $urandom, $urandom, $urandom};
    write_en = 2'b11; tick(); write_en = 2'b00; tick();
    w_data_in = {$urandom, $urandom, $urandom, $urandom};
    write_en = 2'b11; tick(); write_en = 2'b00;
    wait_vld();
    chk("full_both", write_rdy, 2'b00);
    reset = 1'b1;
    #1;
    chk("mid_rst_vld", r_data_vld, 1'b0);
    chk("mid_rst_rdy", write_rdy, 2'b11);
    chk("mid_rst_ack", write_ack, 2'b00);
    chk("mid_rst_fu", on_off_vector_fu, 1'b0);
    chk("mid_rst_config", config_in, 16'h0);
    chk("mid_rst_adder", adder_inputs, '0);
    tick(); reset = 1'b0; tick();

    // Randomized traffic
    cfg_write(W'($urandom) | 16'h0001);
    for (int i = 0; i < 600; i++) begin
      on_off     = ($urandom_range(0, 7) != 0);
      r_data_rdy = on_off ? 1'($urandom_range(0, 1)) : 1'b0;
      write_en   = NP'($urandom);
      w_data_in  = {$urandom, $urandom, $urandom, $urandom};
      if (!on_off && $urandom_range(0, 3) == 0) begin
        cfg_write_en = 1'b1; cfg_data_in = W'($urandom);
      end else begin
        cfg_write_en = 1'b0;
      end
      tick();
    end
    write_en = '0; cfg_write_en = 1'b0;
    if (!m_cfg_valid) cfg_write(16'h0001);
    on_off = 1'b1; r_data_rdy = 1'b1;
    repeat (30) tick();
    ne = 1'b1;
    for (int p = 0; p < NP; p++) if (m_q[p].size() == 0) ne = 1'b0;
    chk("drained", ne, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
